regfile_hilo: RTL and testbench

Architectural state block at the write end of the WB-to-register-file interface. It holds the 32×32 general-purpose register file and the HI/LO pair. All writes come from the WB stage over `wb_to_rf_bus`. The decode stage reads two GPRs plus HI and LO. A same-cycle write-to-read bypass makes a value written back in WB visible to ID in that same cycle.

---
 rtl/regfile_hilo_pkg.sv | 30 +++
 rtl/regfile_hilo_hilo_reg.sv | 40 ++++
 rtl/regfile_hilo.sv | 69 ++++++
 tb/tb_regfile_hilo.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_hilo_pkg.sv
// Shared types and widths for the WB-to-register-file interface.
// Holds the packed layout of wb_to_rf_bus and the datapath widths. The WB
// stage and regfile_hilo both unpack the bus through wb_to_rf_t, so no
// literal bit indices appear in either.
package regfile_hilo_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ADDR_W      = 5;
  localparam int unsigned NUM_REGS    = 32;
  localparam int unsigned WB_TO_RF_WD = 104;

  // Field order is MSB first:
  // lo_we[103] lo_wdata[102:71] hi_we[70] hi_wdata[69:38]
  // rf_we[37] rf_waddr[36:32] rf_wdata[31:0]
  typedef struct packed {
    logic              lo_we;
    logic [DATA_W-1:0] lo_wdata;
    logic              hi_we;
    logic [DATA_W-1:0] hi_wdata;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
  } wb_to_rf_t;

  // Reinterpret the flat bus as its field struct.
  function automatic wb_to_rf_t unpack_wb_to_rf(input logic [WB_TO_RF_WD-1:0] bus);
    return wb_to_rf_t'(bus);
  endfunction

endpackage

// File: rtl/regfile_hilo_hilo_reg.sv
// HI/LO register pair with optional write-through bypass.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   hi_we, hi_wdata     HI write enable/data from WB
//   lo_we, lo_wdata     LO write enable/data from WB
//   hi_rdata, lo_rdata  current HI/LO (bus data when BYPASS and enabled)
module hilo_reg
  import regfile_hilo_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hi_we,
  input  logic [DATA_W-1:0] hi_wdata,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] lo_wdata,
  output logic [DATA_W-1:0] hi_rdata,
  output logic [DATA_W-1:0] lo_rdata
);

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // HI and LO update independently; both may write in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= hi_wdata;
      if (lo_we) lo_q <= lo_wdata;
    end
  end

  // Same-cycle forwarding of the value being written back.
  assign hi_rdata = (BYPASS && hi_we) ? hi_wdata : hi_q;
  assign lo_rdata = (BYPASS && lo_we) ? lo_wdata : lo_q;

endmodule

// File: rtl/regfile_hilo.sv
// Architectural state at the write end of the WB-to-register-file bus:
// 31 stored GPRs ($0 hardwired to zero) plus the HI/LO pair.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wb_to_rf_bus    write bus from WB (see wb_to_rf_t)
//   raddr1/rdata1   GPR read port 1 (combinational)
//   raddr2/rdata2   GPR read port 2 (combinational)
//   hi_rdata        current HI
//   lo_rdata        current LO
module regfile_hilo
  import regfile_hilo_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus,
  input  logic [ADDR_W-1:0]      raddr1,
  output logic [DATA_W-1:0]      rdata1,
  input  logic [ADDR_W-1:0]      raddr2,
  output logic [DATA_W-1:0]      rdata2,
  output logic [DATA_W-1:0]      hi_rdata,
  output logic [DATA_W-1:0]      lo_rdata
);

  wb_to_rf_t wb;
  assign wb = unpack_wb_to_rf(wb_to_rf_bus);

  logic [DATA_W-1:0] gpr_q  [1:NUM_REGS-1];
  logic [DATA_W-1:0] stored [NUM_REGS];
  logic              hit1;
  logic              hit2;

  // GPR array; writes to $0 are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) gpr_q[i] <= '0;
    end else if (wb.rf_we && (wb.rf_waddr != '0)) begin
      gpr_q[wb.rf_waddr] <= wb.rf_wdata;
    end
  end

  // Read view with entry 0 tied to zero so address 0 needs no special case.
  always_comb begin
    stored[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) stored[i] = gpr_q[i];
  end

  // Bypass never fires for $0, so a discarded write cannot leak through.
  assign hit1 = BYPASS && wb.rf_we && (wb.rf_waddr == raddr1) && (raddr1 != '0);
  assign hit2 = BYPASS && wb.rf_we && (wb.rf_waddr == raddr2) && (raddr2 != '0);

  assign rdata1 = hit1 ? wb.rf_wdata : stored[raddr1];
  assign rdata2 = hit2 ? wb.rf_wdata : stored[raddr2];

  hilo_reg #(
    .BYPASS (BYPASS)
  ) u_hilo_reg (
    .clk      (clk),
    .rst      (rst),
    .hi_we    (wb.hi_we),
    .hi_wdata (wb.hi_wdata),
    .lo_we    (wb.lo_we),
    .lo_wdata (wb.lo_wdata),
    .hi_rdata (hi_rdata),
    .lo_rdata (lo_rdata)
  );

endmodule

// File: tb/tb_regfile_hilo.sv
// Scoreboard bench for regfile_hilo: one instance with BYPASS=1 and one with
// BYPASS=0 share all inputs; an array-based model predicts both.
module tb_regfile_hilo;

  logic         clk;
  logic         rst;
  logic [103:0] bus;
  logic [4:0]   raddr1;
  logic [4:0]   raddr2;
  logic [31:0]  rdata1_b, rdata2_b, hi_b, lo_b;
  logic [31:0]  rdata1_n, rdata2_n, hi_n, lo_n;

  regfile_hilo #(.BYPASS(1'b1)) dut_byp (
    .clk(clk), .rst(rst), .wb_to_rf_bus(bus),
    .raddr1(raddr1), .rdata1(rdata1_b),
    .raddr2(raddr2), .rdata2(rdata2_b),
    .hi_rdata(hi_b), .lo_rdata(lo_b)
  );

  regfile_hilo #(.BYPASS(1'b0)) dut_nobyp (
    .clk(clk), .rst(rst), .wb_to_rf_bus(bus),
    .raddr1(raddr1), .rdata1(rdata1_n),
    .raddr2(raddr2), .rdata2(rdata2_n),
    .hi_rdata(hi_n), .lo_rdata(lo_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: plain arrays, updated once per modelled clock edge.
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  typedef struct {
    logic [31:0] v [8];
    int          step;
  } exp_t;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step     = 0;
  bit   stim_done = 0;

  string nm [8] = '{"rdata1_byp", "rdata2_byp", "hi_byp", "lo_byp",
                    "rdata1_nobyp", "rdata2_nobyp", "hi_nobyp", "lo_nobyp"};

  function automatic logic [103:0] mk_bus(input bit lo_we, input logic [31:0] lo_d,
                                          input bit hi_we, input logic [31:0] hi_d,
                                          input bit rf_we, input logic [4:0] wa,
                                          input logic [31:0] wd);
    return {lo_we, lo_d, hi_we, hi_d, rf_we, wa, wd};
  endfunction

  function automatic logic [31:0] model_gpr_read(input bit byp, input logic [4:0] a,
                                                 input bit we, input logic [4:0] wa,
                                                 input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (byp && we && wa == a) return wd;
    return m_gpr[a];
  endfunction

  // Drive one cycle just after the rising edge, queue its expected outputs,
  // then advance the model past the coming edge.
  task automatic cycle(input logic [103:0] b, input logic [4:0] a1,
                       input logic [4:0] a2, input bit r);
    exp_t        e;
    bit          lo_we, hi_we, rf_we;
    logic [31:0] lo_d, hi_d, wd;
    logic [4:0]  wa;
    @(posedge clk);
    #1;
    bus = b; raddr1 = a1; raddr2 = a2; rst = r;
    {lo_we, lo_d, hi_we, hi_d, rf_we, wa, wd} = b;
    if (r) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
      m_hi = 32'h0;
      m_lo = 32'h0;
    end
    e.v[0] = model_gpr_read(1'b1, a1, rf_we, wa, wd);
    e.v[1] = model_gpr_read(1'b1, a2, rf_we, wa, wd);
    e.v[2] = hi_we ? hi_d : m_hi;
    e.v[3] = lo_we ? lo_d : m_lo;
    e.v[4] = model_gpr_read(1'b0, a1, rf_we, wa, wd);
    e.v[5] = model_gpr_read(1'b0, a2, rf_we, wa, wd);
    e.v[6] = m_hi;
    e.v[7] = m_lo;
    e.step = step;
    exp_q.push_back(e);
    step++;
    if (!r) begin
      if (rf_we && wa != 5'd0) m_gpr[wa] = wd;
      if (hi_we) m_hi = hi_d;
      if (lo_we) m_lo = lo_d;
    end
  endtask

  // Monitor: combinational outputs are sampled mid-cycle on the falling edge.
  initial begin
    exp_t        e;
    logic [31:0] got [8];
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        got = '{rdata1_b, rdata2_b, hi_b, lo_b, rdata1_n, rdata2_n, hi_n, lo_n};
        for (int k = 0; k < 8; k++) begin
          n_checks++;
          if (got[k] === e.v[k]) n_pass++;
          else $display("FAIL step %0d %s: got %h expected %h", e.step, nm[k], got[k], e.v[k]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]  a1, a2, wa;
    logic [31:0] z;
    z = 32'h0;
    rst = 1'b1; bus = '0; raddr1 = '0; raddr2 = '0;
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
    m_hi = 32'h0; m_lo = 32'h0;

    // Power-on reset: everything reads zero.
    for (int i = 0; i < 3; i++) cycle('0, 5'(i + 4), 5'(31 - i), 1'b1);

    // Write r5 and HI/LO, read back, then reset asynchronously mid-cycle.
    cycle(mk_bus(1'b1, 32'h0BAD_F00D, 1'b1, 32'hCAFE_0001, 1'b1, 5'd5, 32'h1234_5678), 5'd5, 5'd5, 1'b0);
    cycle('0, 5'd5, 5'd0, 1'b0);
    cycle('0, 5'd5, 5'd0, 1'b1);
    cycle('0, 5'd5, 5'd0, 1'b0);

    // $0 protection.
    cycle(mk_bus(1'b0, z, 1'b0, z, 1'b1, 5'd0, 32'hFFFF_FFFF), 5'd0, 5'd0, 1'b0);
    cycle('0, 5'd0, 5'd0, 1'b0);

    // Bypass on both ports, then storage next cycle.
    cycle(mk_bus(1'b0, z, 1'b0, z, 1'b1, 5'd7, 32'hDEAD_BEEF), 5'd7, 5'd7, 1'b0);
    cycle('0, 5'd7, 5'd7, 1'b0);

    // Dual HI/LO write, then LO alone.
    cycle(mk_bus(1'b1, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b0, 5'd0, z), 5'd7, 5'd0, 1'b0);
    cycle(mk_bus(1'b1, 32'h0000_0005, 1'b0, z, 1'b0, 5'd0, z), 5'd7, 5'd0, 1'b0);
    cycle('0, 5'd0, 5'd0, 1'b0);

    // Load r1..r31 with distinct values, then 10 zero-bus cycles.
    for (int i = 1; i < 32; i++)
      cycle(mk_bus(1'b0, z, 1'b0, z, 1'b1, 5'(i), 32'hA500_0000 + 32'(i * 4099)), 5'(i), 5'(32 - i), 1'b0);
    for (int i = 0; i < 10; i++) cycle('0, 5'(i * 3 + 1), 5'(31 - i), 1'b0);
    for (int i = 0; i < 32; i++) cycle('0, 5'(i), 5'(31 - i), 1'b0);

    // Back-to-back writes to r3.
    cycle(mk_bus(1'b0, z, 1'b0, z, 1'b1, 5'd3, 32'hA), 5'd0, 5'd3, 1'b0);
    cycle(mk_bus(1'b0, z, 1'b0, z, 1'b1, 5'd3, 32'hB), 5'd0, 5'd3, 1'b0);
    cycle('0, 5'd0, 5'd3, 1'b0);

    // Randomized traffic; write address often matches a read port.
    for (int i = 0; i < 400; i++) begin
      a1 = 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0: wa = a1;
        1: wa = a2;
        2: wa = 5'd0;
        default: wa = 5'($urandom_range(0, 31));
      endcase
      cycle(mk_bus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
                   1'($urandom_range(0, 1)), wa, $urandom),
            a1, a2, ($urandom_range(0, 99) == 0));
    end
    cycle('0, 5'd1, 5'd2, 1'b0);

    @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
